// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared mode encoding for the LED NCO/PWM controller
// Contents: mode_t (2-bit display mode), MODE_RESET (mode after reset/srst),
//           next_mode() (OFF -> ON -> BLINK -> BREATHE -> OFF).
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  localparam mode_t MODE_RESET = MODE_BLINK;

  function automatic mode_t next_mode(input mode_t m);
    return mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/led_nco_channel.sv
// rtl/led_nco_channel.sv - one LED channel: phase accumulator, tick, blink toggle, breathe ramp, LED compare
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   srst_i            synchronous clear (same effect as reset)
//   mode_i            current display mode
//   mode_change_i     high in the cycle the mode register advances
//   pwm_cnt_i         shared free-running PWM counter
//   phase_inc_i       accumulator increment for this channel
//   brightness_i      ON-mode duty for this channel
//   tick_o            registered accumulator carry-out (one-cycle pulse)
//   led_o             registered LED drive
module led_nco_channel
  import led_ctrl_pkg::*;
#(
  parameter int ACC_WIDTH = 24,
  parameter int PWM_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 srst_i,
  input  mode_t                mode_i,
  input  logic                 mode_change_i,
  input  logic [PWM_BITS-1:0]  pwm_cnt_i,
  input  logic [ACC_WIDTH-1:0] phase_inc_i,
  input  logic [PWM_BITS-1:0]  brightness_i,
  output logic                 tick_o,
  output logic                 led_o
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 tick_q, tick_d;
  logic                 toggle_q, toggle_d;
  logic [PWM_BITS-1:0]  duty_q, duty_d;
  logic                 dir_up_q, dir_up_d;
  logic                 led_q, led_d;

  always_comb begin
    {tick_d, acc_d} = {1'b0, acc_q} + {1'b0, phase_inc_i};

    toggle_d = toggle_q;
    duty_d   = duty_q;
    dir_up_d = dir_up_q;
    // A tick landing in the mode-change cycle is swallowed by the clear.
    if (mode_change_i) begin
      toggle_d = 1'b0;
      duty_d   = '0;
      dir_up_d = 1'b1;
    end else if (tick_q) begin
      toggle_d = ~toggle_q;
      // Triangle ramp: the end points are visited once, never repeated.
      if (dir_up_q) begin
        if (duty_q == DUTY_MAX) begin
          duty_d   = DUTY_MAX - 1'b1;
          dir_up_d = 1'b0;
        end else begin
          duty_d = duty_q + 1'b1;
        end
      end else begin
        if (duty_q == '0) begin
          duty_d   = PWM_BITS'(1);
          dir_up_d = 1'b1;
        end else begin
          duty_d = duty_q - 1'b1;
        end
      end
    end

    led_d = 1'b0;
    case (mode_i)
      MODE_OFF:     led_d = 1'b0;
      MODE_ON:      led_d = (pwm_cnt_i < brightness_i);
      MODE_BLINK:   led_d = toggle_q;
      MODE_BREATHE: led_d = (pwm_cnt_i < duty_q);
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q    <= '0;
      tick_q   <= 1'b0;
      toggle_q <= 1'b0;
      duty_q   <= '0;
      dir_up_q <= 1'b1;
      led_q    <= 1'b0;
    end else if (srst_i) begin
      acc_q    <= '0;
      tick_q   <= 1'b0;
      toggle_q <= 1'b0;
      duty_q   <= '0;
      dir_up_q <= 1'b1;
      led_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      tick_q   <= tick_d;
      toggle_q <= toggle_d;
      duty_q   <= duty_d;
      dir_up_q <= dir_up_d;
      led_q    <= led_d;
    end
  end

  assign tick_o = tick_q;
  assign led_o  = led_q;

endmodule

// File: rtl/led_nco_pwm_ctrl.sv
// rtl/led_nco_pwm_ctrl.sv - multi-channel LED driver with per-channel NCO, shared PWM and debounced mode button
// Ports:
//   clk          system clock
//   resetn       asynchronous active-low reset
//   srst         synchronous clear, active-high
//   btn_mode     raw asynchronous mode button, active-high
//   phase_inc    per-channel accumulator increment, channel k at [k*ACC_WIDTH +: ACC_WIDTH]
//   brightness   per-channel ON-mode duty, channel k at [k*PWM_BITS +: PWM_BITS]
//   led_out      registered LED drive per channel
//   tick_out     one-cycle accumulator overflow pulse per channel
//   mode_out     current mode (0 OFF, 1 ON, 2 BLINK, 3 BREATHE)
module led_nco_pwm_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int ACC_WIDTH       = 24,
  parameter int PWM_BITS        = 8,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        srst,
  input  logic                        btn_mode,
  input  logic [NUM_CH*ACC_WIDTH-1:0] phase_inc,
  input  logic [NUM_CH*PWM_BITS-1:0]  brightness,
  output logic [NUM_CH-1:0]           led_out,
  output logic [NUM_CH-1:0]           tick_out,
  output logic [1:0]                  mode_out
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic                btn_meta_q, btn_sync_q;
  logic                db_state_q, db_state_d;
  logic                db_prev_q;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic                mode_adv;
  mode_t               mode_q, mode_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;

  // Stability counter: counts consecutive cycles where the synchronised
  // button disagrees with the accepted state; any agreement restarts it.
  always_comb begin
    db_state_d = db_state_q;
    db_cnt_d   = '0;
    if (btn_sync_q != db_state_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_state_d = btn_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Press (not release) of the debounced button; acted on one edge later.
  assign mode_adv = db_state_q & ~db_prev_q;

  // Mode state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q <= MODE_RESET;
    end else if (srst) begin
      mode_q <= MODE_RESET;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Mode next-state
  always_comb begin
    mode_d = mode_q;
    if (mode_adv) begin
      mode_d = next_mode(mode_q);
    end
  end

  // Mode output
  always_comb begin
    mode_out = mode_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      db_state_q <= 1'b0;
      db_prev_q  <= 1'b0;
      db_cnt_q   <= '0;
      pwm_cnt_q  <= '0;
    end else if (srst) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      db_state_q <= 1'b0;
      db_prev_q  <= 1'b0;
      db_cnt_q   <= '0;
      pwm_cnt_q  <= '0;
    end else begin
      btn_meta_q <= btn_mode;
      btn_sync_q <= btn_meta_q;
      db_state_q <= db_state_d;
      db_prev_q  <= db_state_q;
      db_cnt_q   <= db_cnt_d;
      pwm_cnt_q  <= pwm_cnt_q + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : gen_ch
    led_nco_channel #(
      .ACC_WIDTH (ACC_WIDTH),
      .PWM_BITS  (PWM_BITS)
    ) u_ch (
      .clk           (clk),
      .resetn        (resetn),
      .srst_i        (srst),
      .mode_i        (mode_q),
      .mode_change_i (mode_adv),
      .pwm_cnt_i     (pwm_cnt_q),
      .phase_inc_i   (phase_inc[k*ACC_WIDTH +: ACC_WIDTH]),
      .brightness_i  (brightness[k*PWM_BITS +: PWM_BITS]),
      .tick_o        (tick_out[k]),
      .led_o         (led_out[k])
    );
  end

endmodule

// File: tb/tb_led_nco_pwm_ctrl.sv
// tb/tb_led_nco_pwm_ctrl.sv - scoreboard bench for led_nco_pwm_ctrl with a behavioural reference model
module tb_led_nco_pwm_ctrl;

  localparam int NC   = 2;
  localparam int AW   = 8;
  localparam int PB   = 4;
  localparam int DB   = 4;
  localparam int PMAX = (1 << PB) - 1;
  localparam int AMOD = 1 << AW;
  localparam int PMOD = 1 << PB;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              srst = 1'b0;
  logic              btn_mode = 1'b0;
  logic [NC*AW-1:0]  phase_inc = '0;
  logic [NC*PB-1:0]  brightness = '0;
  logic [NC-1:0]     led_out;
  logic [NC-1:0]     tick_out;
  logic [1:0]        mode_out;

  int checks = 0;
  int failures = 0;

  led_nco_pwm_ctrl #(
    .NUM_CH          (NC),
    .ACC_WIDTH       (AW),
    .PWM_BITS        (PB),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .srst       (srst),
    .btn_mode   (btn_mode),
    .phase_inc  (phase_inc),
    .brightness (brightness),
    .led_out    (led_out),
    .tick_out   (tick_out),
    .mode_out   (mode_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC-1:0] led;
    logic [NC-1:0] tick;
    logic [1:0]    mode;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state, described as the observable behaviour:
  // blink/breathe derive from the number of ticks seen since the last mode change.
  int m_s1, m_s2, m_deb, m_dprev, m_run, m_mode, m_pwm;
  int m_acc[NC];
  int m_tick[NC];
  int m_n[NC];
  int m_led[NC];

  function automatic int tri_duty(input int n);
    int p;
    p = n % (2 * PMAX);
    return (p <= PMAX) ? p : (2 * PMAX - p);
  endfunction

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_deb = 0; m_dprev = 0; m_run = 0; m_mode = 2; m_pwm = 0;
    for (int k = 0; k < NC; k++) begin
      m_acc[k] = 0; m_tick[k] = 0; m_n[k] = 0; m_led[k] = 0;
    end
  endtask

  task automatic model_push();
    exp_t e;
    for (int k = 0; k < NC; k++) begin
      e.led[k]  = (m_led[k] != 0);
      e.tick[k] = (m_tick[k] != 0);
    end
    e.mode = 2'(m_mode);
    exp_q.push_back(e);
  endtask

  task automatic model_step();
    int adv, nd, nr, sum, l, br, inc;
    if (!resetn) begin
      exp_q.delete();
      model_clear();
      model_push();
      return;
    end
    if (srst) begin
      model_clear();
      model_push();
      return;
    end
    adv = (m_deb == 1 && m_dprev == 0) ? 1 : 0;
    nd = m_deb;
    nr = 0;
    if (m_s2 != m_deb) begin
      if (m_run == DB - 1) nd = 1 - m_deb;
      else nr = m_run + 1;
    end
    for (int k = 0; k < NC; k++) begin
      br  = int'(brightness[k*PB +: PB]);
      inc = int'(phase_inc[k*AW +: AW]);
      case (m_mode)
        0: l = 0;
        1: l = (m_pwm < br) ? 1 : 0;
        2: l = m_n[k] % 2;
        default: l = (m_pwm < tri_duty(m_n[k])) ? 1 : 0;
      endcase
      m_led[k] = l;
      m_n[k]   = adv ? 0 : m_n[k] + m_tick[k];
      sum      = m_acc[k] + inc;
      m_tick[k] = (sum >= AMOD) ? 1 : 0;
      m_acc[k]  = sum % AMOD;
    end
    m_dprev = m_deb;
    m_deb   = nd;
    m_run   = nr;
    m_s2    = m_s1;
    m_s1    = btn_mode ? 1 : 0;
    m_mode  = adv ? (m_mode + 1) % 4 : m_mode;
    m_pwm   = (m_pwm + 1) % PMOD;
    model_push();
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge resetn);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        if ({led_out, tick_out, mode_out} !== {mon_e.led, mon_e.tick, mon_e.mode}) begin
          failures++;
          $display("FAIL scoreboard t=%0t got led=%b tick=%b mode=%0d expected led=%b tick=%b mode=%0d",
                   $time, led_out, tick_out, mode_out, mon_e.led, mon_e.tick, mon_e.mode);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    btn_mode = 1'b1;
    cyc(10);
    btn_mode = 1'b0;
    cyc(10);
  endtask

  task automatic count_window(input string name, input int expect_ch0_tick);
    int t0, t1;
    t0 = 0; t1 = 0;
    repeat (16) begin
      @(negedge clk);
      t0 += int'(tick_out[0]);
      t1 += int'(tick_out[1]);
    end
    check({name, "_tick0"}, t0, expect_ch0_tick);
    check({name, "_tick1"}, t1, 0);
    cyc(1);
  endtask

  initial begin
    int c0, c1, tries;
    phase_inc  = {8'd0, 8'd64};
    brightness = {4'd0, 4'd5};
    cyc(3);
    resetn = 1'b1;
    cyc(4);
    count_window("blink_window", 4);
    cyc(20);

    // Short press ignored, long press advances exactly once, holding does nothing.
    btn_mode = 1'b1; cyc(3);
    btn_mode = 1'b0; cyc(6);
    check("short_press_mode", int'(mode_out), 2);
    btn_mode = 1'b1; cyc(10);
    check("long_press_mode", int'(mode_out), 3);
    cyc(10);
    check("hold_mode", int'(mode_out), 3);
    btn_mode = 1'b0; cyc(10);

    press();
    press();
    check("on_mode", int'(mode_out), 1);

    c0 = 0; c1 = 0;
    repeat (16) begin
      @(negedge clk);
      c0 += int'(led_out[0]);
      c1 += int'(led_out[1]);
    end
    check("on_duty_ch0", c0, 5);
    check("on_duty_ch1", c1, 0);
    cyc(1);

    repeat (8) begin
      brightness = NC*PB'($urandom);
      phase_inc  = NC*AW'($urandom);
      cyc(5);
    end

    press();
    press();
    check("breathe_mode", int'(mode_out), 3);
    phase_inc = {8'(AW'($urandom)), 8'd128};
    cyc(130);

    repeat (60) begin
      btn_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) phase_inc = NC*AW'($urandom);
      if ($urandom_range(0, 3) == 0) brightness = NC*PB'($urandom);
      cyc($urandom_range(1, 8));
    end
    btn_mode = 1'b0;
    cyc(10);

    // Synchronous clear while in ON with ticks running.
    phase_inc  = {8'd96, 8'd64};
    brightness = NC*PB'($urandom);
    tries = 0;
    while (mode_out != 2'd1 && tries < 5) begin
      press();
      tries++;
    end
    check("pre_srst_mode", int'(mode_out), 1);
    cyc(7);
    srst = 1'b1;
    btn_mode = 1'b1;
    cyc(1);
    srst = 1'b0;
    btn_mode = 1'b0;
    @(negedge clk);
    check("srst_mode", int'(mode_out), 2);
    check("srst_led", int'(led_out), 0);
    check("srst_tick", int'(tick_out), 0);
    cyc(20);
    check("post_srst_mode", int'(mode_out), 2);

    // Asynchronous reset in mid-cycle, then the power-up scenario again.
    brightness = {4'd0, 4'd5};
    phase_inc  = {8'd0, 8'd64};
    cyc(9);
    #2;
    resetn = 1'b0;
    #1;
    check("async_mode", int'(mode_out), 2);
    check("async_led", int'(led_out), 0);
    check("async_tick", int'(tick_out), 0);
    cyc(2);
    resetn = 1'b1;
    cyc(4);
    count_window("reblink_window", 4);
    cyc(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
